// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, write-allocate data cache controller with one-word lines.
// Reads that miss fetch from memory; a flush sweeps the valid bits; hit/miss counters saturate.
module dm_cache_ctrl #(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 12,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_valid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              flush,
  output logic              flush_busy,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);
  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MEM_RD, S_MEM_WR, S_RESP, S_FLUSH
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                lookup_hit_q;
  logic [INDEX_W-1:0]  flush_idx_q;
  logic [LINES-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_mem  [LINES];
  logic [DATA_W-1:0]   data_mem [LINES];
  logic                cpu_valid_q, cpu_hit_q, mem_req_q, mem_we_q, flush_busy_q;
  logic [DATA_W-1:0]   cpu_rdata_q, mem_wdata_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [CNT_W-1:0]    hit_cnt_q, miss_cnt_q;

  logic [INDEX_W-1:0]  idx_s;
  logic [TAG_W-1:0]    tag_s;
  logic                hit_s;
  logic                line_we_s;
  logic [DATA_W-1:0]   line_data_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  // Lookup on the latched request and the line fill selected by the pending memory op.
  always_comb begin
    idx_s       = addr_q[INDEX_W-1:0];
    tag_s       = addr_q[ADDR_W-1:INDEX_W];
    hit_s       = valid_q[idx_s] && (tag_mem[idx_s] == tag_s);
    line_we_s   = 1'b0;
    line_data_s = wdata_q;
    if (mem_ack && (state_q == S_MEM_RD)) begin
      line_we_s   = 1'b1;
      line_data_s = mem_rdata;
    end else if (mem_ack && (state_q == S_MEM_WR)) begin
      line_we_s   = 1'b1;
      line_data_s = wdata_q;
    end else begin
      line_we_s   = 1'b0;
    end
  end

  // Tag/data arrays carry no reset: only the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (line_we_s) begin
      tag_mem[idx_s]  <= tag_s;
      data_mem[idx_s] <= line_data_s;
    end
  end

  // Controller FSM with all outputs, counters and valid bits registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      lookup_hit_q <= 1'b0;
      flush_idx_q  <= '0;
      valid_q      <= '0;
      cpu_valid_q  <= 1'b0;
      cpu_hit_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      flush_busy_q <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (flush) begin
            state_q      <= S_FLUSH;
            flush_busy_q <= 1'b1;
            flush_idx_q  <= '0;
          end else if (cpu_req) begin
            state_q <= S_LOOKUP;
            addr_q  <= cpu_addr;
            we_q    <= cpu_we;
            wdata_q <= cpu_wdata;
          end
        end
        S_LOOKUP: begin
          lookup_hit_q <= hit_s;
          if (hit_s) begin
            hit_cnt_q <= sat_inc(hit_cnt_q);
          end else begin
            miss_cnt_q <= sat_inc(miss_cnt_q);
          end
          if (we_q) begin
            state_q     <= S_MEM_WR;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= addr_q;
            mem_wdata_q <= wdata_q;
          end else if (hit_s) begin
            state_q     <= S_RESP;
            cpu_valid_q <= 1'b1;
            cpu_hit_q   <= 1'b1;
            cpu_rdata_q <= data_mem[idx_s];
          end else begin
            state_q    <= S_MEM_RD;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= addr_q;
          end
        end
        S_MEM_RD, S_MEM_WR: begin
          if (mem_ack) begin
            state_q        <= S_RESP;
            valid_q[idx_s] <= 1'b1;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            cpu_valid_q    <= 1'b1;
            cpu_hit_q      <= lookup_hit_q && (state_q == S_MEM_WR);
            cpu_rdata_q    <= line_data_s;
          end
        end
        S_RESP: begin
          cpu_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        S_FLUSH: begin
          valid_q[flush_idx_q] <= 1'b0;
          flush_idx_q          <= flush_idx_q + INDEX_W'(1);
          if (flush_idx_q == {INDEX_W{1'b1}}) begin
            state_q      <= S_IDLE;
            flush_busy_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cpu_ready  = (state_q == S_IDLE) && !flush;
  assign cpu_valid  = cpu_valid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_hit    = cpu_hit_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign flush_busy = flush_busy_q;
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Self-checking bench for dm_cache_ctrl: directed scenarios plus randomized traffic against
// a model that tracks which address each index holds and a flat backing memory.
module tb_dm_cache_ctrl;
  localparam int AW = 15;
  localparam int DW = 32;
  localparam int IW = 12;
  localparam int CW = 4;
  localparam int LINES = 4096;
  localparam int CNT_MAX = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ready, cpu_valid, cpu_hit;
  logic [DW-1:0] cpu_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          flush = 1'b0;
  logic          flush_busy;
  logic [CW-1:0] hit_cnt, miss_cnt;

  int checks = 0;
  int errors = 0;
  int cached [LINES];
  logic [DW-1:0] mmem [int];
  int m_hit, m_miss;

  always #5 clk = ~clk;

  dm_cache_ctrl #(.ADDR_W(AW), .DATA_W(DW), .INDEX_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_valid(cpu_valid), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .flush(flush), .flush_busy(flush_busy), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) cached[i] = -1;
    m_hit  = 0;
    m_miss = 0;
  endtask

  function automatic int sat(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  // One complete CPU access; lat = idle cycles before mem_ack when memory is involved.
  task automatic do_access(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input int lat, input string name);
    int idx;
    bit exp_hit;
    logic [DW-1:0] memval, exp_rdata;
    idx = int'(addr) % LINES;
    exp_hit = (cached[idx] == int'(addr));
    if (!mmem.exists(int'(addr))) mmem[int'(addr)] = $urandom;
    memval = mmem[int'(addr)];
    exp_rdata = we ? wdata : memval;

    checks++;
    if (cpu_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready: got %b want 1", name, cpu_ready);
    end
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    step();
    cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = AW'($urandom); cpu_wdata = $urandom;

    checks++;
    if (cpu_valid !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL %s lookup_cycle: valid=%b mem_req=%b want 0 0", name, cpu_valid, mem_req);
    end
    step();

    if (we || !exp_hit) begin
      for (int c = 0; c <= lat; c++) begin
        checks++;
        if (mem_req !== 1'b1 || mem_we !== we || mem_addr !== addr ||
            (we && mem_wdata !== wdata) || cpu_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s mem_hold c=%0d: req=%b we=%b addr=%h wdata=%h valid=%b want 1 %b %h %h 0",
                   name, c, mem_req, mem_we, mem_addr, mem_wdata, cpu_valid, we, addr, wdata);
        end
        if (c == lat) begin
          mem_ack = 1'b1;
          mem_rdata = we ? $urandom : memval;
        end
        step();
      end
      mem_ack = 1'b0;
      mem_rdata = $urandom;
    end

    if (exp_hit) m_hit = sat(m_hit);
    else m_miss = sat(m_miss);
    cached[idx] = int'(addr);
    if (we) mmem[int'(addr)] = wdata;

    checks++;
    if (cpu_valid !== 1'b1 || cpu_rdata !== exp_rdata || cpu_hit !== exp_hit || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL %s resp: valid=%b rdata=%h hit=%b mem_req=%b want 1 %h %b 0",
               name, cpu_valid, cpu_rdata, cpu_hit, mem_req, exp_rdata, exp_hit);
    end
    checks++;
    if (hit_cnt !== CW'(m_hit) || miss_cnt !== CW'(m_miss)) begin
      errors++;
      $display("FAIL %s counters: hit=%0d miss=%0d want %0d %0d", name, hit_cnt, miss_cnt, m_hit, m_miss);
    end
    step();
    checks++;
    if (cpu_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s valid_pulse: got %b want 0", name, cpu_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    checks++;
    if (cpu_valid !== 1'b0 || cpu_hit !== 1'b0 || cpu_rdata !== '0 || mem_req !== 1'b0 ||
        mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 || flush_busy !== 1'b0 ||
        hit_cnt !== '0 || miss_cnt !== '0 || cpu_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: valid=%b hit=%b rdata=%h req=%b we=%b addr=%h wdata=%h busy=%b hc=%0d mc=%0d ready=%b",
               cpu_valid, cpu_hit, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata, flush_busy,
               hit_cnt, miss_cnt, cpu_ready);
    end
    step();
    step();
    rst = 1'b1;
    model_reset();
    step();
  endtask

  task automatic test_read_miss_hit();
    mmem[32'h0123] = 32'hDEADBEEF;
    do_access(1'b0, 15'h0123, 32'h0, 1, "read_miss");
    checks++;
    if (miss_cnt !== 4'd1 || hit_cnt !== 4'd0) begin
      errors++;
      $display("FAIL first_miss_cnt: miss=%0d hit=%0d want 1 0", miss_cnt, hit_cnt);
    end
    do_access(1'b0, 15'h0123, 32'h0, 0, "read_hit");
    checks++;
    if (hit_cnt !== 4'd1) begin
      errors++;
      $display("FAIL first_hit_cnt: got %0d want 1", hit_cnt);
    end
  endtask

  task automatic test_conflict();
    do_access(1'b0, 15'h1123, 32'h0, 2, "conflict_new");
    do_access(1'b0, 15'h0123, 32'h0, 0, "conflict_old");
  endtask

  task automatic test_write();
    do_access(1'b1, 15'h2456, 32'hCAFEF00D, 3, "write_miss");
    do_access(1'b0, 15'h2456, 32'h0, 0, "read_after_write");
  endtask

  task automatic test_flush();
    int cnt;
    bit stray;
    int h0, m0;
    do_access(1'b0, 15'h0010, 32'h0, 0, "fill_a");
    do_access(1'b0, 15'h0020, 32'h0, 1, "fill_b");
    do_access(1'b1, 15'h0030, 32'h12345678, 0, "fill_c");
    h0 = m_hit; m0 = m_miss;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0010; flush = 1'b1;
    #1;
    checks++;
    if (cpu_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: got %b want 0", cpu_ready);
    end
    step();
    cpu_req = 1'b0;
    cnt = 0;
    stray = 1'b0;
    while (flush_busy === 1'b1 && cnt < 5000) begin
      if (cnt == 10) flush = 1'b0;
      if (cpu_valid !== 1'b0 || mem_req !== 1'b0) stray = 1'b1;
      cnt++;
      step();
    end
    flush = 1'b0;
    checks++;
    if (cnt != 4096) begin
      errors++;
      $display("FAIL flush_len: got %0d cycles want 4096", cnt);
    end
    checks++;
    if (stray || cpu_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_quiet: stray=%b want 0", stray);
    end
    for (int i = 0; i < LINES; i++) cached[i] = -1;
    checks++;
    if (hit_cnt !== CW'(h0) || miss_cnt !== CW'(m0)) begin
      errors++;
      $display("FAIL flush_counters: hit=%0d miss=%0d want %0d %0d", hit_cnt, miss_cnt, h0, m0);
    end
    do_access(1'b0, 15'h0010, 32'h0, 0, "after_flush");
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int n = 0; n < 80; n++) begin
      a = AW'(($urandom_range(0, 7) << 12) | $urandom_range(0, 3));
      do_access($urandom_range(0, 2) == 0, a, $urandom, $urandom_range(0, 3), "random");
      if ($urandom_range(0, 4) == 0) begin
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        checks++;
        if (cpu_valid !== 1'b0 || mem_req !== 1'b0) begin
          errors++;
          $display("FAIL stray_ack: valid=%b req=%b want 0 0", cpu_valid, mem_req);
        end
      end
    end
  endtask

  task automatic test_reset_mid_miss();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0777;
    step();
    cpu_req = 1'b0;
    step();
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL midmiss_req: got %b want 1", mem_req);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || cpu_valid !== 1'b0 ||
        hit_cnt !== '0 || miss_cnt !== '0 || flush_busy !== 1'b0) begin
      errors++;
      $display("FAIL midmiss_reset: req=%b we=%b addr=%h valid=%b hc=%0d mc=%0d busy=%b want all 0",
               mem_req, mem_we, mem_addr, cpu_valid, hit_cnt, miss_cnt, flush_busy);
    end
    model_reset();
    step();
    rst = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'h55AA55AA;
    step();
    mem_ack = 1'b0;
    checks++;
    if (cpu_valid !== 1'b0 || mem_req !== 1'b0 || hit_cnt !== '0 || miss_cnt !== '0) begin
      errors++;
      $display("FAIL late_ack: valid=%b req=%b hc=%0d mc=%0d want 0 0 0 0", cpu_valid, mem_req, hit_cnt, miss_cnt);
    end
    step();
    do_access(1'b0, 15'h0777, 32'h0, 1, "after_reset_read");
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 20; n++) do_access(1'b0, 15'h0777, 32'h0, 0, "sat_hit");
    checks++;
    if (hit_cnt !== 4'd15 || miss_cnt !== 4'd1) begin
      errors++;
      $display("FAIL saturation: hit=%0d miss=%0d want 15 1", hit_cnt, miss_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_read_miss_hit();
    test_conflict();
    test_write();
    test_flush();
    test_random();
    test_reset_mid_miss();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
